// File: rtl/fmo_reader.sv
`default_nettype none
// ============================================================================
// fmo_reader : drains a pixel tile from the FMO tile RAM onto a valid/ready stream
// Revision   : 1.0  initial release
// ============================================================================
module fmo_reader #(
  parameter int FMO_N_ELEM = 1024,
  parameter int PX_W       = 16,
  parameter int AW         = $clog2(FMO_N_ELEM),
  parameter int LW         = $clog2(FMO_N_ELEM) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  input  logic [LW-1:0]   len,
  output logic            ram_rd,
  output logic [AW-1:0]   ram_addr,
  output logic            ram_write,
  input  logic [PX_W-1:0] ram_res,
  output logic [PX_W-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] c_N_ELEM = (AW+1)'(FMO_N_ELEM);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_base;
  logic [LW-1:0]   r_len;
  logic [LW-1:0]   r_rd_cnt;
  logic [LW-1:0]   r_out_cnt;
  logic            r_in_flight;
  logic [PX_W-1:0] r_buf [2];
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [1:0]      r_buf_cnt;

  logic            w_push;
  logic            w_pop;
  logic            w_issue;
  logic            w_last_rd;
  logic            w_accept;
  logic [2:0]      w_occ;
  logic [AW:0]     w_addr_sum;
  logic [AW:0]     w_addr_mod;

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_push    = r_in_flight;
  assign out_valid = (r_buf_cnt != 2'd0);
  assign out_data  = r_buf[r_rd_ptr];
  assign out_last  = out_valid && (r_out_cnt == r_len - LW'(1));
  assign w_pop     = out_valid && out_ready;

  // Occupancy after this cycle's pop: buffered words plus the read still in flight.
  assign w_occ   = {1'b0, r_buf_cnt} + {2'b00, r_in_flight} - {2'b00, w_pop};
  assign w_issue = (r_state == S_RUN) && (r_rd_cnt < r_len) && (w_occ < 3'd2);
  assign w_last_rd = (r_rd_cnt + LW'(1)) == r_len;

  // While issuing, rd_cnt < len <= FMO_N_ELEM, so its low AW bits hold the full offset.
  assign w_addr_sum = {1'b0, r_base} + {1'b0, r_rd_cnt[AW-1:0]};
  assign w_addr_mod = (w_addr_sum >= c_N_ELEM) ? (w_addr_sum - c_N_ELEM) : w_addr_sum;

  assign ram_rd    = w_issue;
  assign ram_addr  = w_issue ? w_addr_mod[AW-1:0] : '0;
  assign ram_write = 1'b0;
  assign busy      = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign done      = (r_state == S_DONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_issue && w_last_rd) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (w_pop && out_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_rd_cnt    <= '0;
      r_out_cnt   <= '0;
      r_in_flight <= 1'b0;
      r_buf[0]    <= '0;
      r_buf[1]    <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_buf_cnt   <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_flight <= w_issue;
      if (w_accept) begin
        r_base    <= base_addr;
        r_len     <= len;
        r_rd_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_issue) begin
          r_rd_cnt <= r_rd_cnt + LW'(1);
        end
        if (w_pop) begin
          r_out_cnt <= r_out_cnt + LW'(1);
        end
      end
      // RAM data lands one cycle after its read; the issue rule guarantees room.
      if (w_push) begin
        r_buf[r_wr_ptr] <= ram_res;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_buf_cnt <= r_buf_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire
